// File: rtl/alu_mul_seq.sv
// alu_mul_seq: unsigned shift-add multiplier, WIDTH x WIDTH -> 2*WIDTH product with zero/overflow flags.
// Latency: WIDTH clocks from accept edge to out_valid (early exit with ALU_MUL_EARLY_EXIT_EN: max(1, msb(b)+1)).
// Backpressure: one op in flight; in_ready only in IDLE; result held in DONE until out_ready.
module alu_mul_seq #(
    parameter int WIDTH = 8
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [WIDTH-1:0]     a_i,
    input  logic [WIDTH-1:0]     b_i,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [2*WIDTH-1:0]   product_o,
    output logic                 zero_o,
    output logic                 ovf_o,
    output logic                 busy_o
);

    localparam int PW    = 2 * WIDTH;
    localparam int CNT_W = $clog2(WIDTH);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t             state_q, state_d;
    logic [PW-1:0]      acc_q, acc_d;
    logic [PW-1:0]      mcand_q, mcand_d;
    logic [WIDTH-1:0]   mplier_q, mplier_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [PW-1:0]      product_q, product_d;
    logic               zero_q, zero_d;
    logic               ovf_q, ovf_d;
    logic               last_step;

    // Next-state and datapath: accept in IDLE, one multiplier bit per RUN clock, hold in DONE.
    always_comb begin
        state_d   = state_q;
        acc_d     = acc_q;
        mcand_d   = mcand_q;
        mplier_d  = mplier_q;
        cnt_d     = cnt_q;
        product_d = product_q;
        zero_d    = zero_q;
        ovf_d     = ovf_q;
        last_step = 1'b0;

        case (state_q)
            IDLE: begin
                if (in_valid) begin
                    mcand_d  = {{WIDTH{1'b0}}, a_i};
                    mplier_d = b_i;
                    acc_d    = '0;
                    cnt_d    = '0;
                    state_d  = RUN;
                end
            end
            RUN: begin
                // Carry-out cannot occur: an unsigned WIDTH x WIDTH product fits in 2*WIDTH bits.
                if (mplier_q[0]) begin
                    acc_d = acc_q + mcand_q;
                end
                mcand_d   = mcand_q << 1;
                mplier_d  = mplier_q >> 1;
                cnt_d     = cnt_q + 1'b1;
                last_step = (cnt_q == CNT_W'(WIDTH - 1));
`ifdef ALU_MUL_EARLY_EXIT_EN
                // No set bits left in the multiplier: remaining steps would add nothing.
                if (mplier_d == '0) begin
                    last_step = 1'b1;
                end
`endif
                if (last_step) begin
                    state_d   = DONE;
                    product_d = acc_d;
                    zero_d    = (acc_d == '0);
                    ovf_d     = |acc_d[PW-1:WIDTH];
                end
            end
            DONE: begin
                if (out_ready) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State and datapath registers; reset aborts any operation in flight.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            acc_q     <= '0;
            mcand_q   <= '0;
            mplier_q  <= '0;
            cnt_q     <= '0;
            product_q <= '0;
            zero_q    <= 1'b0;
            ovf_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            acc_q     <= acc_d;
            mcand_q   <= mcand_d;
            mplier_q  <= mplier_d;
            cnt_q     <= cnt_d;
            product_q <= product_d;
            zero_q    <= zero_d;
            ovf_q     <= ovf_d;
        end
    end

    // Handshake and status outputs decoded from state only.
    always_comb begin
        in_ready  = (state_q == IDLE);
        out_valid = (state_q == DONE);
        busy_o    = (state_q != IDLE);
        product_o = product_q;
        zero_o    = zero_q;
        ovf_o     = ovf_q;
    end

endmodule

// File: tb/tb_alu_mul_seq.sv
// tb_alu_mul_seq: directed vector table plus hand sequences for back-pressure and mid-run reset.
// Latency: checks accept-to-out_valid edge count and accept-to-accept spacing.
// Backpressure: holds out_ready low in DONE and confirms outputs stay frozen.
module tb_alu_mul_seq;

    logic        clk;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [7:0]  a_i;
    logic [7:0]  b_i;
    logic        out_valid;
    logic        out_ready;
    logic [15:0] product_o;
    logic        zero_o;
    logic        ovf_o;
    logic        busy_o;

    int n_tests = 0;
    int n_fail  = 0;
    int cyc     = 0;

    alu_mul_seq #(.WIDTH(8)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a_i       (a_i),
        .b_i       (b_i),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .product_o (product_o),
        .zero_o    (zero_o),
        .ovf_o     (ovf_o),
        .busy_o    (busy_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    typedef struct packed {
        logic [7:0]  a;
        logic [7:0]  b;
        logic [15:0] p;
        logic        z;
        logic        o;
        logic [7:0]  lat_f;
        logic [7:0]  lat_e;
    } vec_t;

    localparam int NV = 10;
    vec_t vecs [NV];

    task automatic check(input string name, input int got, input int exp);
        n_tests++;
        if (got != exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, got, exp);
        end
    endtask

    function automatic int pick_lat(input vec_t v);
`ifdef ALU_MUL_EARLY_EXIT_EN
        return int'(v.lat_e);
`else
        return int'(v.lat_f);
`endif
    endfunction

    // One full operation with out_ready=1; returns the cycle number of the accept edge.
    task automatic run_op(input vec_t v, input int lat_exp, output int acc_cyc);
        int  lat;
        bit  got;
        check("in_ready_idle", int'(in_ready), 1);
        a_i       = v.a;
        b_i       = v.b;
        in_valid  = 1'b1;
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        acc_cyc  = cyc;
        in_valid = 1'b0;
        check("busy_run", int'({busy_o, in_ready, out_valid}), 3'b100);
        lat = 0;
        got = 0;
        while (!got && lat < 40) begin
            @(posedge clk);
            #1;
            lat++;
            if (out_valid) got = 1;
        end
        check("latency", lat, lat_exp);
        check("product", int'(product_o), int'(v.p));
        check("flags", int'({zero_o, ovf_o}), int'({v.z, v.o}));
        @(posedge clk);
        #1;
        check("handoff", int'({out_valid, in_ready, busy_o}), 3'b010);
        check("product_hold", int'(product_o), int'(v.p));
    endtask

    initial begin
        int acc_c [NV];
        int a0;
        bit ok;
        bit seen;

        //           a      b      product  z     o     lat_f lat_e
        vecs[0] = '{8'd150, 8'd150, 16'h57E4, 1'b0, 1'b1, 8'd8, 8'd8};
        vecs[1] = '{8'd255, 8'd255, 16'hFE01, 1'b0, 1'b1, 8'd8, 8'd8};
        vecs[2] = '{8'd12,  8'd10,  16'h0078, 1'b0, 1'b0, 8'd8, 8'd4};
        vecs[3] = '{8'd0,   8'd200, 16'h0000, 1'b1, 1'b0, 8'd8, 8'd8};
        vecs[4] = '{8'd3,   8'd5,   16'h000F, 1'b0, 1'b0, 8'd8, 8'd3};
        vecs[5] = '{8'd3,   8'd2,   16'h0006, 1'b0, 1'b0, 8'd8, 8'd2};
        vecs[6] = '{8'd1,   8'd1,   16'h0001, 1'b0, 1'b0, 8'd8, 8'd1};
        vecs[7] = '{8'd255, 8'd1,   16'h00FF, 1'b0, 1'b0, 8'd8, 8'd1};
        vecs[8] = '{8'd16,  8'd16,  16'h0100, 1'b0, 1'b1, 8'd8, 8'd5};
        vecs[9] = '{8'd200, 8'd0,   16'h0000, 1'b1, 1'b0, 8'd8, 8'd1};

        rst_n     = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        a_i       = '0;
        b_i       = '0;
        #2;
        check("reset_outs", int'({out_valid, busy_o, zero_o, ovf_o}), 0);
        check("reset_product", int'(product_o), 0);
        @(posedge clk);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        check("reset_in_ready", int'(in_ready), 1);

        // Vector table, each op issued the cycle right after the previous handoff.
        for (int i = 0; i < NV; i++) begin
            run_op(vecs[i], pick_lat(vecs[i]), acc_c[i]);
            if (i > 0) check("spacing", acc_c[i] - acc_c[i-1], pick_lat(vecs[i-1]) + 2);
        end

        // Back-pressure: result held for 20 clocks with new operands waiting.
        a_i       = 8'd150;
        b_i       = 8'd150;
        in_valid  = 1'b1;
        out_ready = 1'b0;
        @(posedge clk);
        #1;
        a_i = 8'd7;
        b_i = 8'd9;
        seen = 0;
        for (int k = 0; k < 40 && !seen; k++) begin
            @(posedge clk);
            #1;
            if (out_valid) seen = 1;
        end
        check("bp_reach_done", int'(seen), 1);
        ok = 1;
        for (int k = 0; k < 20; k++) begin
            @(posedge clk);
            #1;
            if (!(out_valid && !in_ready && product_o == 16'h57E4 && ovf_o && !zero_o)) ok = 0;
        end
        check("bp_hold", int'(ok), 1);
        in_valid  = 1'b0;
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        check("bp_release", int'({out_valid, in_ready}), 2'b01);
        check("bp_product_kept", int'(product_o), 16'h57E4);

        // Reset in the middle of RUN at count=4.
        a_i      = 8'd150;
        b_i      = 8'd150;
        in_valid = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        repeat (4) @(posedge clk);
        #1;
        check("pre_reset_busy", int'({busy_o, out_valid}), 2'b10);
        rst_n = 1'b0;
        #1;
        check("midrun_reset_outs", int'({out_valid, busy_o, zero_o, ovf_o}), 0);
        check("midrun_reset_product", int'(product_o), 0);
        check("midrun_reset_ready", int'(in_ready), 1);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        seen = 0;
        for (int k = 0; k < 12; k++) begin
            @(posedge clk);
            #1;
            if (out_valid || busy_o) seen = 1;
        end
        check("no_pulse_after_reset", int'(seen), 0);
        run_op(vecs[4], pick_lat(vecs[4]), a0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    // Global watchdog so the bench always terminates.
    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, got timeout expected finish");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/alu_mul_seq.md
Name: alu_mul_seq

Overview:
- Multi-cycle unsigned shift-add multiplier in the ALU operand path.
- Sits directly upstream of the 16-bit adder stage: it takes two WIDTH-bit operands and produces a 2*WIDTH-bit product.
- That product is consumed as a 16-bit adder operand, so a multiply-accumulate is a multiply followed by a 16-bit add.
- Uses valid/ready handshakes on both sides. One operation is in flight at a time.

Parameters:
- WIDTH, 8, operand width in bits; product width is 2*WIDTH; legal range 2..16.

Ports:
- clk  input  1  system clock, rising-edge.
- rst_n  input  1  asynchronous active-low reset.
- in_valid  input  1  operands a_i/b_i are valid.
- in_ready  output  1  block can accept operands.
- a_i  input  WIDTH  multiplicand.
- b_i  input  WIDTH  multiplier.
- out_valid  output  1  product_o and flags are valid.
- out_ready  input  1  downstream adder stage accepts the result.
- product_o  output  2*WIDTH  a*b, unsigned.
- zero_o  output  1  product == 0.
- ovf_o  output  1  product upper WIDTH bits non-zero (result does not fit in WIDTH).
- busy_o  output  1  high while state != IDLE.

Interface (already decided):
- One clock, clk.
- Reset is asynchronous and active-low, rst_n.

Behaviour:
- States: IDLE, RUN, DONE. Encoded as registered state with a next-state block.
- Reset (asynchronous on rst_n low), regardless of current state:
  - state=IDLE.
  - product_o=0, zero_o=0, ovf_o=0, out_valid=0, busy_o=0.
  - Internal accumulator, multiplicand shift register, multiplier shift register and bit counter all cleared.
  - in_ready=1 after reset releases.
- in_ready = (state==IDLE). It is combinational from state only.
- Accept edge: in IDLE with in_valid=1:
  - Latch a_i zero-extended to 2*WIDTH into the multiplicand register; latch b_i into the multiplier register.
  - Clear the accumulator, set count=0, go to RUN.
- RUN, one multiplier bit per clock:
  - If multiplier[0]=1, acc <= acc + mcand (2*WIDTH-bit add, carry-out discarded; it cannot occur for unsigned operands).
  - mcand <= mcand << 1; multiplier <= multiplier >> 1; count <= count+1.
  - When count==WIDTH-1 on the edge, go to DONE.
  - RUN lasts exactly WIDTH clocks.
- Latency: out_valid rises WIDTH clock edges after the accept edge (8 for the default WIDTH).
- DONE:
  - out_valid=1.
  - product_o = acc; zero_o = (acc==0); ovf_o = |acc[2*WIDTH-1:WIDTH].
  - Outputs hold stable while out_ready=0 (back-pressure, no limit).
  - On an edge with out_ready=1, go to IDLE. out_valid drops on that edge.
  - product_o and flags keep their last value after the handoff until the next DONE.
- Simultaneous events:
  - in_valid during RUN or DONE is ignored (in_ready=0). The upstream stage must hold its operands.
  - A new operation can be accepted at the earliest one clock after the DONE handoff.
- Back-to-back throughput: one result per WIDTH+2 clocks (accept edge, WIDTH RUN edges, handoff edge).
- Reset mid-RUN or mid-DONE: the operation is aborted immediately. No out_valid pulse is produced.
- Operand latches are never updated outside the accept edge.

Optional Feature:
- Macro: ALU_MUL_EARLY_EXIT_EN.
- Defined:
  - In RUN, when the multiplier register after the current shift is all zero, go to DONE on that edge even if count < WIDTH-1.
  - If b_i==0 at accept, RUN still lasts 1 clock.
  - Latency becomes max(1, index of the highest set bit of b_i + 1) clocks.
  - Product values are unchanged.
- Undefined: fixed WIDTH-clock RUN for every operand pair.

Test Plan:
- a=150, b=150, out_ready=1 -> out_valid 8 edges after accept; product_o=0x57E4 (22500); ovf_o=1; zero_o=0.
- a=255, b=255 -> product_o=0xFE01; ovf_o=1. Then a=12, b=10 accepted the cycle after handoff -> product_o=0x0078; ovf_o=0; total 10 clocks per op.
- a=0, b=200 -> product_o=0x0000; zero_o=1; ovf_o=0.
- Result 0x57E4 in DONE, out_ready held 0 for 20 clocks while in_valid=1 with new operands:
  - out_valid stays 1, product_o stable, in_ready=0.
  - After out_ready=1 for one clock, out_valid=0 and in_ready=1.
- rst_n pulsed low at count=4 during a=150, b=150 -> all outputs 0 at once; no out_valid pulse. Next op a=3, b=5 -> 0x000F.
- With ALU_MUL_EARLY_EXIT_EN: a=3, b=2 -> out_valid 2 edges after accept, product_o=0x0006. Same stimulus without the macro -> 8 edges.
